// File: rtl/ddr2_port_arbiter_if.sv
// Requester-side command/write/read-steer signals plus the DDR2 AF/WDF/RDF push/pop bundle.
// slave = arbiter view, master = requesters and FIFO-side view.
interface ddr2_port_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_is_read;
   logic [N_REQ-1:0][30:0]   req_addr;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ-1:0]         wd_valid;
   logic [N_REQ-1:0][127:0]  wd_data;
   logic [N_REQ-1:0][15:0]   wd_mask;
   logic [N_REQ-1:0]         wd_ready;
   logic [N_REQ-1:0]         rd_valid;
   logic                     af_full;
   logic                     af_wr_en;
   logic [2:0]               af_cmd_din;
   logic [30:0]              af_addr_din;
   logic                     wdf_full;
   logic                     wdf_wr_en;
   logic [127:0]             wdf_din;
   logic [15:0]              wdf_mask_din;
   logic                     rdf_valid;
   logic                     rdf_rd_en;

   modport slave (
      input  req_valid, req_is_read, req_addr, wd_valid, wd_data, wd_mask,
      input  af_full, wdf_full, rdf_valid,
      output req_ready, wd_ready, rd_valid, af_wr_en, af_cmd_din, af_addr_din,
      output wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
   );

   modport master (
      output req_valid, req_is_read, req_addr, wd_valid, wd_data, wd_mask,
      output af_full, wdf_full, rdf_valid,
      input  req_ready, wd_ready, rd_valid, af_wr_en, af_cmd_din, af_addr_din,
      input  wdf_wr_en, wdf_din, wdf_mask_din, rdf_rd_en
   );
endinterface

// File: rtl/ddr2_port_arbiter.sv
// Round-robin sharing of the DDR2 AF/WDF/RDF; grants are combinational (zero latency),
// writes hold the WDF until all beats land, reads are tagged so RDF beats steer back.
module ddr2_port_arbiter #(
   parameter int N_REQ     = 4,
   parameter int TAG_DEPTH = 8,
   parameter int WR_BEATS  = 2,
   parameter int RD_BEATS  = 2
) (
   input  logic                clk,
   input  logic                rst,
   ddr2_port_arbiter_if.slave  bus,
   output logic                busy,
   output logic                err_orphan
);
   localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW  = $clog2(TAG_DEPTH);
   localparam int WCW = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
   localparam int RCW = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
   localparam logic [WCW-1:0] WR_LAST = WCW'(WR_BEATS - 1);
   localparam logic [RCW-1:0] RD_LAST = RCW'(RD_BEATS - 1);

   typedef enum logic {ARB, WDATA} state_t;

   state_t           state, state_nx;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    wsel;
   logic [WCW-1:0]   wr_cnt;
   logic [RCW-1:0]   rd_cnt;
   logic [IW-1:0]    tag_mem [TAG_DEPTH];
   logic [TW:0]      tag_wp, tag_rp;
   logic             tag_empty, tag_full;
   logic [IW-1:0]    tag_head;
   logic [N_REQ-1:0] elig;
   logic [IW-1:0]    gnt, idx;
   logic             gnt_any, gnt_rd;
   logic             tag_push, tag_pop;

   assign tag_empty = (tag_wp == tag_rp);
   assign tag_full  = (tag_wp[TW] != tag_rp[TW]) && (tag_wp[TW-1:0] == tag_rp[TW-1:0]);
   assign tag_head  = tag_mem[tag_rp[TW-1:0]];

   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         elig[i] = bus.req_valid[i] && !bus.af_full &&
                   (bus.req_is_read[i] ? !tag_full : !bus.wdf_full);
   end

   // First eligible requester at or after the round-robin pointer.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % N_REQ);
         if (!gnt_any && elig[idx]) begin
            gnt     = idx;
            gnt_any = 1'b1;
         end
      end
   end

   assign gnt_rd = bus.req_is_read[gnt];

   always_comb begin
      state_nx         = state;
      bus.req_ready    = '0;
      bus.af_wr_en     = 1'b0;
      bus.af_cmd_din   = 3'b000;
      bus.af_addr_din  = '0;
      bus.wd_ready     = '0;
      bus.wdf_wr_en    = 1'b0;
      bus.wdf_din      = '0;
      bus.wdf_mask_din = '0;
      if (rst) begin
         case (state)
            ARB: begin
               if (gnt_any) begin
                  bus.req_ready[gnt] = 1'b1;
                  bus.af_wr_en       = 1'b1;
                  bus.af_addr_din    = bus.req_addr[gnt];
                  bus.af_cmd_din     = {2'b00, gnt_rd};
                  if (!gnt_rd)
                     state_nx = WDATA;
               end
            end
            WDATA: begin
               bus.wd_ready[wsel] = !bus.wdf_full;
               if (bus.wd_valid[wsel] && !bus.wdf_full) begin
                  bus.wdf_wr_en    = 1'b1;
                  bus.wdf_din      = bus.wd_data[wsel];
                  bus.wdf_mask_din = bus.wd_mask[wsel];
                  if (wr_cnt == WR_LAST)
                     state_nx = ARB;
               end
            end
            default: state_nx = ARB;
         endcase
      end
   end

   // Read return runs regardless of arbitration state.
   assign bus.rdf_rd_en = rst && bus.rdf_valid && !tag_empty;
   assign tag_push      = rst && (state == ARB) && gnt_any && gnt_rd;
   assign tag_pop       = bus.rdf_rd_en && (rd_cnt == RD_LAST);
   assign busy          = rst && ((state == WDATA) || !tag_empty);

   always_comb begin
      bus.rd_valid           = '0;
      bus.rd_valid[tag_head] = bus.rdf_rd_en;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ARB;
         ptr        <= '0;
         wsel       <= '0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         tag_wp     <= '0;
         tag_rp     <= '0;
         err_orphan <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == ARB) && gnt_any) begin
            ptr <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
            if (!gnt_rd) begin
               wsel   <= gnt;
               wr_cnt <= '0;
            end
         end
         if (bus.wdf_wr_en)
            wr_cnt <= (wr_cnt == WR_LAST) ? '0 : wr_cnt + 1'b1;
         if (tag_push)
            tag_wp <= tag_wp + 1'b1;
         if (bus.rdf_rd_en)
            rd_cnt <= tag_pop ? '0 : rd_cnt + 1'b1;
         if (tag_pop)
            tag_rp <= tag_rp + 1'b1;
         if (bus.rdf_valid && tag_empty)
            err_orphan <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_push)
         tag_mem[tag_wp[TW-1:0]] <= gnt;
   end
endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Directed scenarios then random traffic, every cycle checked against a queue-based model.
module tb_ddr2_port_arbiter;
   localparam int N  = 4;
   localparam int TD = 8;
   localparam int WB = 2;
   localparam int RB = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy, err_orphan;

   always #5 clk = ~clk;

   ddr2_port_arbiter_if #(.N_REQ(N)) bus();

   ddr2_port_arbiter #(.N_REQ(N), .TAG_DEPTH(TD), .WR_BEATS(WB), .RD_BEATS(RB)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_orphan(err_orphan)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: pointer, owning writer (-1 none), beat counts, tag queue.
   int ptr_m = 0, owner_m = -1, wcnt_m = 0, rcnt_m = 0;
   bit err_m = 0;
   int tq[$];

   logic [3:0]   obs_rr, obs_wdr, obs_rdv;
   logic         obs_af, obs_wdf, obs_rden, obs_busy, obs_err;
   logic [2:0]   obs_cmd;
   logic [30:0]  obs_addr;
   logic [127:0] obs_din;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic [3:0] e_rr, e_wdr, e_rdv;
      logic e_af, e_wdf, e_rden, e_busy;
      logic [2:0] e_cmd;
      logic [30:0] e_addr;
      logic [127:0] e_din;
      logic [15:0] e_mask;
      int g;
      @(negedge clk);
      e_rr = '0; e_wdr = '0; e_rdv = '0; e_af = 0; e_wdf = 0; e_rden = 0; e_busy = 0;
      e_cmd = '0; e_addr = '0; e_din = '0; e_mask = '0; g = -1;
      if (rst) begin
         if (bus.rdf_valid && tq.size() > 0) begin
            e_rden = 1;
            e_rdv[tq[0]] = 1'b1;
         end
         if (owner_m < 0) begin
            for (int k = 0; k < N; k++) begin
               int i;
               i = (ptr_m + k) % N;
               if (g < 0 && bus.req_valid[i] && !bus.af_full &&
                   (bus.req_is_read[i] ? (tq.size() < TD) : !bus.wdf_full))
                  g = i;
            end
            if (g >= 0) begin
               e_rr[g] = 1'b1;
               e_af    = 1;
               e_addr  = bus.req_addr[g];
               e_cmd   = {2'b00, bus.req_is_read[g]};
            end
         end else begin
            if (!bus.wdf_full) e_wdr[owner_m] = 1'b1;
            if (bus.wd_valid[owner_m] && !bus.wdf_full) begin
               e_wdf  = 1;
               e_din  = bus.wd_data[owner_m];
               e_mask = bus.wd_mask[owner_m];
            end
         end
         e_busy = (owner_m >= 0) || (tq.size() > 0);
      end
      obs_rr = bus.req_ready; obs_wdr = bus.wd_ready; obs_rdv = bus.rd_valid;
      obs_af = bus.af_wr_en; obs_wdf = bus.wdf_wr_en; obs_rden = bus.rdf_rd_en;
      obs_cmd = bus.af_cmd_din; obs_addr = bus.af_addr_din; obs_din = bus.wdf_din;
      obs_busy = busy; obs_err = err_orphan;
      chk("req_ready", obs_rr, e_rr);
      chk("af_wr_en", obs_af, e_af);
      chk("af_cmd_din", obs_cmd, e_cmd);
      chk("af_addr_din", obs_addr, e_addr);
      chk("wd_ready", obs_wdr, e_wdr);
      chk("wdf_wr_en", obs_wdf, e_wdf);
      chk("wdf_din", obs_din, e_din);
      chk("wdf_mask_din", bus.wdf_mask_din, e_mask);
      chk("rdf_rd_en", obs_rden, e_rden);
      chk("rd_valid", obs_rdv, e_rdv);
      chk("busy", obs_busy, e_busy);
      chk("err_orphan", obs_err, err_m);
      if (!rst) begin
         ptr_m = 0; owner_m = -1; wcnt_m = 0; rcnt_m = 0; err_m = 0;
         tq.delete();
      end else begin
         if (bus.rdf_valid && tq.size() == 0) err_m = 1;
         if (e_rden) begin
            if (rcnt_m == RB - 1) begin
               void'(tq.pop_front());
               rcnt_m = 0;
            end else rcnt_m++;
         end
         if (g >= 0) begin
            ptr_m = (g + 1) % N;
            if (bus.req_is_read[g]) tq.push_back(g);
            else begin owner_m = g; wcnt_m = 0; end
         end
         if (e_wdf) begin
            wcnt_m++;
            if (wcnt_m == WB) owner_m = -1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 60; k++) begin
         if (tq.size() == 0) break;
         bus.rdf_valid = 1'b1;
         cycle();
      end
      bus.rdf_valid = 1'b0;
      chk("drain_busy", busy, 1'b0);
   endtask

   initial begin
      logic [3:0] one;
      logic [127:0] d1a, d1b;
      int beats;
      one = 4'b0001;
      bus.req_valid = '0; bus.req_is_read = '0; bus.req_addr = '0;
      bus.wd_valid = '0; bus.wd_data = '0; bus.wd_mask = '0;
      bus.af_full = 0; bus.wdf_full = 0; bus.rdf_valid = 0;

      // Reset then idle
      cycle(); cycle();
      rst = 1'b1;
      cycle(); cycle();
      chk("idle_busy", obs_busy, 1'b0);

      // Round-robin reads until the tag FIFO fills
      bus.req_valid = 4'hF; bus.req_is_read = 4'hF;
      for (int i = 0; i < N; i++) bus.req_addr[i] = 31'(32'h1000 * (i + 1));
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rr_grant", obs_rr, one << (i % 4));
         chk("rr_cmd", obs_cmd, 3'b001);
      end
      cycle();
      chk("rr_tagfull", obs_rr, 4'b0000);
      bus.rdf_valid = 1'b1;
      cycle(); chk("rr_wait1", obs_rr, 4'b0000); chk("rr_steer0", obs_rdv, 4'b0001);
      cycle(); chk("rr_wait2", obs_rr, 4'b0000);
      cycle(); chk("rr_after_pop", obs_rr, 4'b0001);
      bus.req_valid = '0;
      drain();

      // Write atomicity: requester 1 writes, requester 2 waits
      d1a = {$urandom, $urandom, $urandom, $urandom};
      d1b = {$urandom, $urandom, $urandom, $urandom};
      bus.req_valid = 4'b0110; bus.req_is_read = 4'b0100;
      bus.req_addr[1] = 31'h100; bus.req_addr[2] = 31'h200;
      bus.wd_valid[3] = 1'b1;
      cycle();
      chk("wr_grant", obs_rr, 4'b0010);
      chk("wr_cmd", obs_cmd, 3'b000);
      chk("wr_addr", obs_addr, 31'h100);
      bus.req_valid[1] = 1'b0;
      bus.wd_data[1] = d1a; bus.wd_mask[1] = 16'hFFFF; bus.wd_valid[1] = 1'b1;
      cycle(); beats = int'(obs_wdf);
      chk("wr_beat1", obs_din, d1a); chk("wr_hold", obs_rr, 4'b0000);
      bus.wd_valid[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(); beats += int'(obs_wdf);
         chk("wr_stall", obs_rr, 4'b0000);
      end
      bus.wd_data[1] = d1b; bus.wd_valid[1] = 1'b1;
      cycle(); beats += int'(obs_wdf);
      chk("wr_beat2", obs_din, d1b); chk("wr_hold2", obs_rr, 4'b0000);
      bus.wd_valid = '0;
      cycle(); beats += int'(obs_wdf);
      chk("wr_next_grant", obs_rr, 4'b0100);
      chk("wr_beats", beats, 2);
      bus.req_valid = '0;
      drain();

      // Read steering: 2 then 0
      bus.req_valid = 4'b0100; bus.req_is_read = 4'hF;
      cycle(); chk("st_g2", obs_rr, 4'b0100);
      bus.req_valid = 4'b0001;
      cycle(); chk("st_g0", obs_rr, 4'b0001);
      bus.req_valid = '0; bus.rdf_valid = 1'b1;
      cycle(); chk("st_b1", obs_rdv, 4'b0100);
      cycle(); chk("st_b2", obs_rdv, 4'b0100);
      cycle(); chk("st_b3", obs_rdv, 4'b0001);
      cycle(); chk("st_b4", obs_rdv, 4'b0001);
      bus.rdf_valid = 1'b0;
      chk("st_empty", busy, 1'b0);

      // AF full, then WDF full during WDATA
      bus.af_full = 1'b1; bus.req_valid = 4'hF; bus.req_is_read = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         cycle(); chk("af_full_rr", obs_rr, 4'b0000); chk("af_full_en", obs_af, 1'b0);
      end
      bus.af_full = 1'b0; bus.req_valid = 4'b0010;
      cycle(); chk("bp_wgrant", obs_rr, 4'b0010);
      bus.req_valid = '0; bus.wdf_full = 1'b1; bus.wd_valid = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         cycle(); chk("wdf_full_rdy", obs_wdr, 4'b0000); chk("wdf_full_en", obs_wdf, 1'b0);
      end
      bus.wdf_full = 1'b0;
      cycle(); chk("wdf_go_rdy", obs_wdr, 4'b0010); chk("wdf_go1", obs_wdf, 1'b1);
      cycle(); chk("wdf_go2", obs_wdf, 1'b1);
      bus.wd_valid = '0;

      // Orphan data then reset inside WDATA
      bus.rdf_valid = 1'b1;
      cycle(); chk("orph_rden", obs_rden, 1'b0);
      bus.rdf_valid = 1'b0;
      cycle(); chk("orph_err", obs_err, 1'b1);
      bus.req_valid = 4'b1000; bus.req_is_read = 4'b0000;
      cycle(); chk("rst_wgrant", obs_rr, 4'b1000);
      bus.req_valid = '0; bus.wd_valid = 4'b1000;
      cycle(); chk("rst_beat1", obs_wdf, 1'b1);
      bus.wd_valid = '0; rst = 1'b0;
      cycle();
      rst = 1'b1; bus.req_valid = 4'b1000; bus.req_is_read = 4'b1000;
      cycle();
      chk("rst_arb", obs_rr, 4'b1000);
      chk("rst_err", obs_err, 1'b0);
      bus.req_valid = '0;
      drain();

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 99) != 0);
         bus.req_valid   = 4'($urandom);
         bus.req_is_read = 4'($urandom);
         bus.wd_valid    = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            bus.req_addr[i] = 31'($urandom);
            bus.wd_data[i]  = {$urandom, $urandom, $urandom, $urandom};
            bus.wd_mask[i]  = 16'($urandom);
         end
         bus.af_full   = ($urandom_range(0, 3) == 0);
         bus.wdf_full  = ($urandom_range(0, 3) == 0);
         bus.rdf_valid = ($urandom_range(0, 1) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
